// File: rtl/melody_pkg.sv
// Pitch codes, the clkgen divider table and the FSM encoding shared by the
// melody sequencer and its bench-facing users.
package melody_pkg;

  localparam int unsigned PITCH_A     = 0;
  localparam int unsigned PITCH_DHIGH = 1;
  localparam int unsigned PITCH_C     = 2;
  localparam int unsigned PITCH_B     = 3;
  localparam int unsigned PITCH_G     = 4;
  localparam int unsigned PITCH_FIS   = 5;
  localparam int unsigned PITCH_E     = 6;
  localparam int unsigned PITCH_D     = 7;
  // All-ones code of the default 4-bit pitch field; every code above 7 is silent.
  localparam int unsigned PITCH_REST  = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_GAP
  } state_t;

  function automatic int unsigned pitch_to_div(input int unsigned code);
    case (code)
      PITCH_A:     return 18;
      PITCH_DHIGH: return 13;
      PITCH_C:     return 15;
      PITCH_B:     return 16;
      PITCH_G:     return 20;
      PITCH_FIS:   return 21;
      PITCH_E:     return 24;
      PITCH_D:     return 27;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/melody_tick.sv
// Sample-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable
// from zero through a synchronous clear so each note starts on a fresh tick.
module melody_tick #(
  parameter int TICK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count_reg;

  assign tick = !clr && (count_reg == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Programmable melody player: steps through a RAM of (pitch, duration) slots
// and drives the sine clkgen divider plus a tone enable for the DAC pair.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int PITCH_W   = 4,
  parameter int DUR_W     = 13,
  parameter int DIV_W     = 5,
  parameter int TICK_DIV  = 125,
  parameter int GAP_TICKS = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [PITCH_W-1:0]         wr_pitch,
  input  logic [DUR_W-1:0]           wr_dur,
  output logic [DIV_W-1:0]           div_out,
  output logic                       tone_on,
  output logic [$clog2(DEPTH)-1:0]   note_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = PITCH_W + DUR_W;
  localparam logic [DUR_W-1:0] GAP_D = DUR_W'(GAP_TICKS);

  logic [RW-1:0]      ram [DEPTH];
  logic [RW-1:0]      rd_data;
  state_t             state_reg, state_next;
  logic [AW-1:0]      note_idx_reg, note_idx_next;
  logic [DUR_W-1:0]   dur_reg, dur_cnt_reg, cnt_inc;
  logic [DIV_W-1:0]   div_reg;
  logic               done_reg, done_next;
  logic               end_of_note, last_note, run, tick;
  logic [PITCH_W-1:0] fetch_pitch;
  logic [DUR_W-1:0]   fetch_dur;

  assign fetch_pitch = rd_data[RW-1:DUR_W];
  assign fetch_dur   = rd_data[DUR_W-1:0];
  assign run         = (state_reg == ST_PLAY) || (state_reg == ST_GAP);
  assign cnt_inc     = dur_cnt_reg + DUR_W'(1);
  assign last_note   = (LW'(note_idx_reg) + LW'(1)) >= len;

  melody_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (reset),
    .clr  (!run),
    .tick (tick)
  );

  // The read address follows the next slot index, so the slot is already
  // sitting in rd_data during the FETCH cycle.
  always_ff @(posedge clk) begin
    if (wr_en && (state_reg == ST_IDLE)) begin
      ram[wr_addr] <= {wr_pitch, wr_dur};
    end
    rd_data <= ram[note_idx_next];
  end

  always_comb begin
    state_next    = state_reg;
    note_idx_next = note_idx_reg;
    done_next     = 1'b0;
    end_of_note   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && !stop) begin
          if (len == '0) begin
            done_next = 1'b1;
          end else begin
            state_next    = ST_FETCH;
            note_idx_next = '0;
          end
        end
      end
      ST_FETCH: begin
        if (fetch_dur == '0) begin
          end_of_note = 1'b1;
        end else if (fetch_dur <= GAP_D) begin
          state_next = ST_GAP;
        end else begin
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Reaching the full duration here only happens with a zero gap.
        if (tick) begin
          if (cnt_inc == dur_reg) begin
            end_of_note = 1'b1;
          end else if (cnt_inc == dur_reg - GAP_D) begin
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tick && (cnt_inc == dur_reg)) begin
          end_of_note = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (end_of_note) begin
      if (!last_note) begin
        note_idx_next = note_idx_reg + AW'(1);
        state_next    = ST_FETCH;
      end else if (loop_en) begin
        note_idx_next = '0;
        state_next    = ST_FETCH;
      end else begin
        note_idx_next = '0;
        state_next    = ST_IDLE;
        done_next     = 1'b1;
      end
    end

    if (stop && (state_reg != ST_IDLE)) begin
      state_next    = ST_IDLE;
      note_idx_next = '0;
      done_next     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      note_idx_reg <= '0;
      done_reg     <= 1'b0;
      dur_reg      <= '0;
      dur_cnt_reg  <= '0;
      div_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      note_idx_reg <= note_idx_next;
      done_reg     <= done_next;
      if (state_reg == ST_FETCH) begin
        dur_reg     <= fetch_dur;
        dur_cnt_reg <= '0;
      end else if (tick) begin
        dur_cnt_reg <= cnt_inc;
      end
      // div_out only changes on entry to PLAY; FETCH and GAP keep the last value.
      if (state_next == ST_IDLE) begin
        div_reg <= '0;
      end else if ((state_reg == ST_FETCH) && (state_next == ST_PLAY)) begin
        div_reg <= DIV_W'(pitch_to_div(32'(fetch_pitch)));
      end
    end
  end

  assign div_out  = div_reg;
  assign tone_on  = (state_reg == ST_PLAY) && (div_reg != '0);
  assign note_idx = note_idx_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed scenarios plus random programs, each
// checked cycle by cycle against a note-schedule model built from the rules.
module tb_melody_sequencer;

  localparam int TD    = 4;
  localparam int GAP   = 1;
  localparam int NEVER = 100000;

  typedef struct {
    bit busy;
    bit tone;
    bit chk_div;
    int div;
    bit chk_idx;
    int idx;
    bit done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop_en;
  logic [3:0]  len;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_pitch;
  logic [12:0] wr_dur;
  logic [4:0]  div_out;
  logic        tone_on;
  logic [2:0]  note_idx;
  logic        busy, done;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   prog_pitch [8];
  int   prog_dur [8];
  exp_t exp_q [$];
  int   dat;

  melody_sequencer #(
    .DEPTH(8), .PITCH_W(4), .DUR_W(13), .DIV_W(5), .TICK_DIV(TD), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch),
    .wr_dur(wr_dur), .div_out(div_out), .tone_on(tone_on),
    .note_idx(note_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic int div_of(input int p);
    case (p)
      0: return 18;
      1: return 13;
      2: return 15;
      3: return 16;
      4: return 20;
      5: return 21;
      6: return 24;
      7: return 27;
      default: return 0;
    endcase
  endfunction

  // Expected per-cycle trace starting at the FETCH of slot 0.
  function automatic void build_trace(input int len_v, input bit loop_v,
                                      input int clear_at, input int stop_at);
    int i, d, dv, play_c, gap_c;
    bit ended;
    exp_t e;
    exp_q.delete();
    i = 0;
    ended = 0;
    while (!ended && exp_q.size() <= stop_at) begin
      d  = prog_dur[i];
      dv = div_of(prog_pitch[i]);
      e = '{busy:1, tone:0, chk_div:0, div:0, chk_idx:1, idx:i, done:0};
      exp_q.push_back(e);
      play_c = (d > GAP) ? (d - GAP) * TD : 0;
      gap_c  = ((d > GAP) ? GAP : d) * TD;
      for (int c = 0; c < play_c; c++) begin
        e.tone = (dv != 0); e.chk_div = 1; e.div = dv;
        exp_q.push_back(e);
      end
      e.tone = 0; e.chk_div = 0;
      for (int c = 0; c < gap_c; c++) exp_q.push_back(e);
      if (i + 1 < len_v) begin
        i++;
      end else if (loop_v && (exp_q.size() - 1) < clear_at) begin
        i = 0;
      end else begin
        e = '{busy:0, tone:0, chk_div:0, div:0, chk_idx:0, idx:0, done:1};
        exp_q.push_back(e);
        ended = 1;
      end
    end
    if (!ended || exp_q.size() > stop_at + 1) begin
      while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
      e = '{busy:0, tone:0, chk_div:1, div:0, chk_idx:1, idx:0, done:0};
      exp_q.push_back(e);
    end
  endfunction

  task automatic write_prog(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1; wr_addr = 3'(i);
      wr_pitch = 4'(prog_pitch[i]); wr_dur = 13'(prog_dur[i]);
      @(posedge clk); #1;
    end
    wr_en = 0;
  endtask

  // Entered and left one time unit after a rising edge with the DUT idle.
  task automatic play(input int len_v, input bit loop_v, input int clear_at,
                      input int stop_at, output int done_at);
    int done_cnt, exp_done;
    build_trace(len_v, loop_v, clear_at, stop_at);
    exp_done = 0;
    foreach (exp_q[j]) if (exp_q[j].done) exp_done++;
    len = 4'(len_v); loop_en = loop_v; start = 1;
    @(posedge clk); #1;
    start = 0;
    done_cnt = 0; done_at = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      stop = (k == stop_at);
      if (k == clear_at) loop_en = 0;
      wr_en    = exp_q[k].busy && ($urandom_range(0, 3) == 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_pitch = 4'($urandom_range(0, 15));
      wr_dur   = 13'($urandom_range(0, 8191));
      @(negedge clk);
      check_eq("busy", int'(busy), int'(exp_q[k].busy));
      check_eq("tone_on", int'(tone_on), int'(exp_q[k].tone));
      check_eq("done", int'(done), int'(exp_q[k].done));
      if (exp_q[k].chk_div) check_eq("div_out", int'(div_out), exp_q[k].div);
      if (exp_q[k].chk_idx) check_eq("note_idx", int'(note_idx), exp_q[k].idx);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      @(posedge clk); #1;
    end
    stop = 0; wr_en = 0; loop_en = 0;
    @(negedge clk);
    check_eq("done_after", int'(done), 0);
    check_eq("busy_after", int'(busy), 0);
    check_eq("done_count", done_cnt, exp_done);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; loop_en = 0; len = 0;
    wr_en = 0; wr_addr = 0; wr_pitch = 0; wr_dur = 0;
    for (int i = 0; i < 8; i++) begin prog_pitch[i] = 0; prog_dur[i] = 1; end
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_tone", int'(tone_on), 0);
    check_eq("rst_div", int'(div_out), 0);
    check_eq("rst_idx", int'(note_idx), 0);
    check_eq("rst_done", int'(done), 0);
    reset = 0;
    @(posedge clk); #1;

    // (A,3), (REST,2), (Dhigh,2): one-shot, then looped with late clear.
    prog_pitch[0] = 0;  prog_dur[0] = 3;
    prog_pitch[1] = 15; prog_dur[1] = 2;
    prog_pitch[2] = 1;  prog_dur[2] = 2;
    write_prog(3);
    play(3, 0, NEVER, NEVER, dat);
    check_eq("oneshot_done_lat", dat, 31);
    play(3, 1, 46, NEVER, dat);
    check_eq("loop_clear_done_lat", dat, 62);
    play(3, 1, NEVER, 75, dat);
    check_eq("loop_stop_no_done", dat, -1);

    // Reset while a note is sounding.
    len = 3; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    #1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_tone", int'(tone_on), 0);
    check_eq("midrst_div", int'(div_out), 0);
    check_eq("midrst_idx", int'(note_idx), 0);
    check_eq("midrst_done", int'(done), 0);
    @(posedge clk); #1;
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("postrst_idle", int'(busy), 0);
      @(posedge clk); #1;
    end

    // Stop during PLAY of slot 1.
    prog_pitch[0] = 0; prog_dur[0] = 3;
    prog_pitch[1] = 2; prog_dur[1] = 3;
    prog_pitch[2] = 7; prog_dur[2] = 2;
    write_prog(3);
    play(3, 0, NEVER, 16, dat);
    check_eq("stop_no_done", dat, -1);

    // Zero-duration skip and a one-tick silent note.
    prog_pitch[0] = 0; prog_dur[0] = 2;
    prog_pitch[1] = 3; prog_dur[1] = 0;
    prog_pitch[2] = 6; prog_dur[2] = 1;
    write_prog(3);
    play(3, 0, NEVER, NEVER, dat);
    check_eq("skip_done_lat", dat, 15);

    // start+stop together in IDLE.
    len = 3; start = 1; stop = 1;
    @(posedge clk); #1;
    start = 0; stop = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("startstop_busy", int'(busy), 0);
      check_eq("startstop_done", int'(done), 0);
      @(posedge clk); #1;
    end

    // start with len=0: done pulse only.
    len = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check_eq("len0_done", int'(done), 1);
    check_eq("len0_busy", int'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("len0_done_off", int'(done), 0);
    check_eq("len0_busy_off", int'(busy), 0);
    @(posedge clk); #1;

    // Random programs, lengths and modes.
    for (int r = 0; r < 20; r++) begin
      int sel, mode, lv;
      for (int i = 0; i < 8; i++) begin
        sel = $urandom_range(0, 11);
        prog_pitch[i] = (sel < 8) ? sel : ((sel == 8) ? 15 : $urandom_range(8, 14));
        prog_dur[i]   = $urandom_range(0, 4);
      end
      write_prog(8);
      lv   = $urandom_range(1, 8);
      mode = $urandom_range(0, 2);
      if (mode == 0) play(lv, 0, NEVER, NEVER, dat);
      else if (mode == 1) play(lv, 0, NEVER, $urandom_range(0, 60), dat);
      else play(lv, 1, $urandom_range(0, 200), $urandom_range(20, 300), dat);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
